// File: rtl/phase_seq.sv
// phase_seq: multi-cycle CPU phase sequencer (f,d,e,m,w) with mem stalls, step, halt and watchdog.
// Optional performance counters enabled by defining PHASE_PERF_CNT_EN.
module phase_seq #(
    parameter int TIMEOUT = 255,
    parameter int TO_W    = 8
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        run,
    input  logic        step,
    input  logic        mem_acc,
    input  logic        halt_req,
    input  logic        mem_ready,
    output logic [4:0]  cur_phase,
    output logic [4:0]  phase,
    output logic        busy,
    output logic        halted,
    output logic        err,
    output logic [31:0] cycle_cnt,
    output logic [31:0] instr_cnt
);
    typedef enum logic [2:0] {IDLE, RUN, STEP, HALT, ERR} state_t;
    state_t state, state_nxt;
    logic [4:0] cur_nxt;
    logic [TO_W-1:0] wcnt, wcnt_nxt;
    logic need_mem, go;
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state     <= IDLE;
            cur_phase <= 5'b00001;
            wcnt      <= '0;
        end else begin
            state     <= state_nxt;
            cur_phase <= cur_nxt;
            wcnt      <= wcnt_nxt;
        end
    end
    always_comb begin
        busy      = (state == RUN) || (state == STEP);
        need_mem  = cur_phase[0] | (cur_phase[3] & mem_acc);
        go        = busy & (!need_mem | mem_ready);
        phase     = go ? cur_phase : 5'b0;
        state_nxt = state;
        cur_nxt   = cur_phase;
        wcnt_nxt  = wcnt;
        if (state == IDLE)
            state_nxt = run ? RUN : step ? STEP : IDLE;
        else if (go) begin
            cur_nxt  = {cur_phase[3:0], cur_phase[4]};
            wcnt_nxt = '0;
            if (cur_phase[4])
                state_nxt = halt_req ? HALT : (state == STEP || !run) ? IDLE : RUN;
        end else if (busy) begin
            wcnt_nxt = wcnt + 1'b1;
            // Trap on the cycle the count would reach TIMEOUT; cur_phase stays frozen.
            if (wcnt_nxt == TO_W'(TIMEOUT))
                state_nxt = ERR;
        end
    end
    assign halted = (state == HALT);
    assign err    = (state == ERR);
`ifdef PHASE_PERF_CNT_EN
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cycle_cnt <= '0;
            instr_cnt <= '0;
        end else begin
            if (busy)
                cycle_cnt <= cycle_cnt + 32'd1;
            if (phase[4])
                instr_cnt <= instr_cnt + 32'd1;
        end
    end
`else
    assign cycle_cnt = '0;
    assign instr_cnt = '0;
`endif
endmodule

// File: tb/tb_phase_seq.sv
// tb_phase_seq: directed plus randomized self-checking bench for phase_seq against a behavioural model.
module tb_phase_seq;
    localparam int TIMEOUT = 4;
    logic clk = 0, n_rst, run, step, mem_acc, halt_req, mem_ready;
    logic [4:0] cur_phase, phase;
    logic busy, halted, err;
    logic [31:0] cycle_cnt, instr_cnt;
    int checks = 0, errors = 0;
    // model: mode 0 idle, 1 run, 2 step, 3 halt, 4 err; idx = phase number 0..4
    int mode, idx, wcnt;
    logic [31:0] m_cyc, m_ins;
    logic [4:0] obs_phase, obs_cur;
    int f_pulses;

    phase_seq #(.TIMEOUT(TIMEOUT), .TO_W(3)) dut (
        .clk(clk), .n_rst(n_rst), .run(run), .step(step), .mem_acc(mem_acc),
        .halt_req(halt_req), .mem_ready(mem_ready), .cur_phase(cur_phase), .phase(phase),
        .busy(busy), .halted(halted), .err(err), .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic bit perf_on();
`ifdef PHASE_PERF_CNT_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    // Called just after a negedge with inputs applied; compares, then advances one clock.
    task automatic cyc();
        bit b, need, g;
        int nmode, nidx, nw;
        b    = (mode == 1) || (mode == 2);
        need = (idx == 0) || (idx == 3 && mem_acc);
        g    = b && (!need || mem_ready);
        #1;
        obs_phase = phase;
        obs_cur   = cur_phase;
        chk("cur_phase", 32'(cur_phase), 32'(1 << idx));
        chk("phase", 32'(phase), g ? 32'(1 << idx) : 32'd0);
        chk("busy", 32'(busy), 32'(b));
        chk("halted", 32'(halted), 32'(mode == 3));
        chk("err", 32'(err), 32'(mode == 4));
        chk("cycle_cnt", cycle_cnt, perf_on() ? m_cyc : 32'd0);
        chk("instr_cnt", instr_cnt, perf_on() ? m_ins : 32'd0);
        nmode = mode; nidx = idx; nw = wcnt;
        if (mode == 0)
            nmode = run ? 1 : step ? 2 : 0;
        else if (g) begin
            nidx = (idx + 1) % 5;
            nw   = 0;
            if (idx == 4)
                nmode = halt_req ? 3 : (mode == 2 || !run) ? 0 : 1;
        end else if (b) begin
            nw = wcnt + 1;
            if (nw == TIMEOUT) nmode = 4;
        end
        if (b) m_cyc = m_cyc + 1;
        if (g && idx == 4) m_ins = m_ins + 1;
        @(posedge clk);
        mode = nmode; idx = nidx; wcnt = nw;
        @(negedge clk);
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear before any clock edge.
    task automatic do_reset();
        run = 0; step = 0; mem_acc = 0; halt_req = 0; mem_ready = 0;
        #1 n_rst = 0;
        #1;
        chk("rst_cur", 32'(cur_phase), 32'd1);
        chk("rst_phase", 32'(phase), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_cyc", cycle_cnt, 32'd0);
        chk("rst_ins", instr_cnt, 32'd0);
        mode = 0; idx = 0; wcnt = 0; m_cyc = 0; m_ins = 0;
        @(negedge clk);
        n_rst = 1;
    endtask

    initial begin
        n_rst = 0; run = 0; step = 0; mem_acc = 0; halt_req = 0; mem_ready = 0;
        mode = 0; idx = 0; wcnt = 0; m_cyc = 0; m_ins = 0;
        @(negedge clk);
        // free run, no stalls
        do_reset();
        run = 1; mem_ready = 1;
        cyc();
        f_pulses = 0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            chk("run_seq", 32'(obs_phase), 32'(1 << (i % 5)));
            if (obs_phase[0]) f_pulses++;
        end
        chk("f_pulses", f_pulses, 2);
        // fetch stall for 3 cycles
        mem_ready = 0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("fstall_phase", 32'(obs_phase), 32'd0);
            chk("fstall_cur", 32'(obs_cur), 32'd1);
        end
        mem_ready = 1;
        cyc();
        chk("fetch_go", 32'(obs_phase), 32'd1);
        for (int i = 0; i < 4; i++) cyc();
        chk("fstall_end", 32'(obs_phase), 32'd16);
        // memory phase stalled 2 cycles
        mem_acc = 1;
        for (int i = 0; i < 3; i++) cyc();
        mem_ready = 0;
        for (int i = 0; i < 2; i++) begin
            cyc();
            chk("mstall_phase", 32'(obs_phase), 32'd0);
            chk("mstall_cur", 32'(obs_cur), 32'd8);
        end
        mem_ready = 1;
        cyc();
        chk("m_go", 32'(obs_phase), 32'd8);
        cyc();
        // mem_acc=0: m completes without mem_ready
        mem_acc = 0;
        for (int i = 0; i < 3; i++) cyc();
        mem_ready = 0;
        cyc();
        chk("m_noacc", 32'(obs_phase), 32'd8);
        cyc();
        chk("w_noready", 32'(obs_phase), 32'd16);
        // single step, second pulse ignored
        do_reset();
        mem_ready = 1; step = 1;
        cyc();
        step = 0;
        cyc();
        chk("step_f", 32'(obs_phase), 32'd1);
        step = 1;
        cyc();
        step = 0;
        for (int i = 0; i < 3; i++) cyc();
        chk("step_w", 32'(obs_phase), 32'd16);
        chk("step_idle", 32'(busy), 32'd0);
        cyc();
        chk("step_noq", 32'(obs_phase), 32'd0);
        // run dropped in d completes through w
        do_reset();
        mem_ready = 1; run = 1;
        cyc(); cyc();
        run = 0;
        for (int i = 0; i < 4; i++) cyc();
        chk("drop_w", 32'(obs_phase), 32'd16);
        chk("drop_idle", 32'(busy), 32'd0);
        // halt at w commit
        run = 1;
        for (int i = 0; i < 5; i++) cyc();
        halt_req = 1;
        cyc();
        halt_req = 0;
        chk("halted", 32'(halted), 32'd1);
        step = 1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("halt_phase", 32'(obs_phase), 32'd0);
        end
        chk("halt_sticky", 32'(halted), 32'd1);
        // watchdog in fetch
        do_reset();
        run = 1; mem_ready = 0;
        cyc();
        for (int i = 0; i < 3; i++) cyc();
        chk("wd_early", 32'(err), 32'd0);
        cyc();
        chk("wd_err", 32'(err), 32'd1);
        chk("wd_cur", 32'(cur_phase), 32'd1);
        mem_ready = 1;
        cyc();
        chk("wd_sticky", 32'(err), 32'd1);
        // reset mid-wait
        do_reset();
        run = 1; mem_ready = 0;
        cyc(); cyc(); cyc();
        do_reset();
        // three clean instructions for counters
        run = 1; mem_ready = 1;
        cyc();
        for (int i = 0; i < 15; i++) cyc();
        chk("perf_instr", instr_cnt, perf_on() ? 32'd3 : 32'd0);
        chk("perf_cycle", cycle_cnt, perf_on() ? 32'd15 : 32'd0);
        // randomized
        for (int blk = 0; blk < 30; blk++) begin
            do_reset();
            for (int i = 0; i < 250; i++) begin
                if ($urandom_range(15) == 0) run = ~run;
                step      = ($urandom_range(7) == 0);
                mem_acc   = $urandom_range(1);
                mem_ready = ($urandom_range(3) != 0);
                halt_req  = ($urandom_range(40) == 0);
                cyc();
            end
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
